// File: rtl/panel_input_conditioner.sv
// Front-panel conditioning: 1 ms tick, 2-flop synchronisers and per-channel debounce for 13 switches and 5 active-low keys,
// then the edge pulses, stop toggle and "next" stretcher that the traffic light controller consumes.
module panel_input_conditioner #(
   parameter int TICK_DIV     = 32768,
   parameter int DEBOUNCE_MS  = 16,
   parameter int NEXT_HOLD_MS = 1000,
   parameter int NSW          = 13
) (
   input  logic           clksrc1_1,
   input  logic           reset,
   input  logic [NSW-1:0] noisy,
   input  logic           next_key_n,
   input  logic           stop_key_n,
   input  logic           plus_key_n,
   input  logic           minus_key_n,
   input  logic           restore_key_n,
   output logic           ms_tick,
   output logic [NSW-1:0] clean,
   output logic [NSW-1:0] sw_rise,
   output logic           plus_pulse,
   output logic           minus_pulse,
   output logic           restore_pulse,
   output logic           stop_state,
   output logic           next_hold
);

   localparam int NCH       = NSW + 5;
   localparam int K_NEXT    = NSW;
   localparam int K_STOP    = NSW + 1;
   localparam int K_PLUS    = NSW + 2;
   localparam int K_MINUS   = NSW + 3;
   localparam int K_RESTORE = NSW + 4;
   localparam int TW        = $clog2(TICK_DIV);
   localparam int CW        = $clog2(DEBOUNCE_MS + 1);
   localparam int HW        = $clog2(NEXT_HOLD_MS + 1);

   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0]  DEB_LAST  = CW'(DEBOUNCE_MS - 1);
   localparam logic [HW-1:0]  HOLD_LOAD = HW'(NEXT_HOLD_MS);
   // Keys idle high (released), switches idle low.
   localparam logic [NCH-1:0] IDLE_LVL  = {5'b11111, {NSW{1'b0}}};

   logic [TW-1:0]  tick_cnt;
   logic [NCH-1:0] raw;
   logic [NCH-1:0] sync_p0;
   logic [NCH-1:0] sync_p1;
   logic [NCH-1:0] lvl;
   logic [NCH-1:0] lvl_p;
   logic [CW-1:0]  deb_cnt [NCH];
   logic [HW-1:0]  hold_cnt;
   logic           press_stop;
   logic           press_plus;
   logic           press_minus;
   logic           press_restore;

   // Shared ms time base
   always_ff @(posedge clksrc1_1) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   assign ms_tick = (tick_cnt == TICK_LAST);

   // Stage p0/p1: two-flop synchroniser for every raw input
   assign raw = {restore_key_n, minus_key_n, plus_key_n, stop_key_n, next_key_n, noisy};

   always_ff @(posedge clksrc1_1) begin
      if (reset) begin
         sync_p0 <= IDLE_LVL;
         sync_p1 <= IDLE_LVL;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   // Debounce: a new level must persist across DEBOUNCE_MS ticks before it is taken
   always_ff @(posedge clksrc1_1) begin
      if (reset) begin
         lvl <= IDLE_LVL;
         for (int i = 0; i < NCH; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (sync_p1[i] == lvl[i]) begin
               deb_cnt[i] <= '0;
            end else if (ms_tick) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  lvl[i]     <= sync_p1[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + CW'(1);
               end
            end
         end
      end
   end

   assign clean = lvl[NSW-1:0];

   // Key presses are debounced 1->0 transitions
   assign press_stop    = lvl_p[K_STOP]    & ~lvl[K_STOP];
   assign press_plus    = lvl_p[K_PLUS]    & ~lvl[K_PLUS];
   assign press_minus   = lvl_p[K_MINUS]   & ~lvl[K_MINUS];
   assign press_restore = lvl_p[K_RESTORE] & ~lvl[K_RESTORE];

   // Stage p2: registered edge pulses, stop toggle and next stretcher
   always_ff @(posedge clksrc1_1) begin
      if (reset) begin
         lvl_p         <= IDLE_LVL;
         sw_rise       <= '0;
         plus_pulse    <= 1'b0;
         minus_pulse   <= 1'b0;
         restore_pulse <= 1'b0;
         stop_state    <= 1'b0;
         hold_cnt      <= '0;
         next_hold     <= 1'b0;
      end else begin
         lvl_p         <= lvl;
         sw_rise       <= lvl[NSW-1:0] & ~lvl_p[NSW-1:0];
         // Restore wins over plus/minus; plus with minus cancels both.
         plus_pulse    <= press_plus  & ~press_minus & ~press_restore;
         minus_pulse   <= press_minus & ~press_plus  & ~press_restore;
         restore_pulse <= press_restore;
         stop_state    <= stop_state ^ press_stop;
         if (!lvl[K_NEXT]) begin
            hold_cnt <= HOLD_LOAD;
         end else if (ms_tick && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HW'(1);
         end
         next_hold     <= ~lvl[K_NEXT] | (hold_cnt != '0);
      end
   end

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Directed bench for panel_input_conditioner: expected values are queued with their due cycle and checked on the falling edge.
module tb_panel_input_conditioner;

   localparam int TICK_DIV = 4;
   localparam int DEB      = 3;
   localparam int HOLD     = 5;
   localparam int NSW      = 13;

   localparam int S_CLEAN = 0, S_RISE = 1, S_PLUS = 2, S_MINUS = 3;
   localparam int S_RESTORE = 4, S_STOP = 5, S_NHOLD = 6, S_TICK = 7;

   logic           clksrc1_1 = 1'b0;
   logic           reset = 1'b1;
   logic [NSW-1:0] noisy = '0;
   logic           next_key_n = 1'b1;
   logic           stop_key_n = 1'b1;
   logic           plus_key_n = 1'b1;
   logic           minus_key_n = 1'b1;
   logic           restore_key_n = 1'b1;
   logic           ms_tick;
   logic [NSW-1:0] clean;
   logic [NSW-1:0] sw_rise;
   logic           plus_pulse, minus_pulse, restore_pulse, stop_state, next_hold;

   panel_input_conditioner #(
      .TICK_DIV(TICK_DIV), .DEBOUNCE_MS(DEB), .NEXT_HOLD_MS(HOLD), .NSW(NSW)
   ) dut (
      .clksrc1_1(clksrc1_1), .reset(reset), .noisy(noisy),
      .next_key_n(next_key_n), .stop_key_n(stop_key_n), .plus_key_n(plus_key_n),
      .minus_key_n(minus_key_n), .restore_key_n(restore_key_n),
      .ms_tick(ms_tick), .clean(clean), .sw_rise(sw_rise),
      .plus_pulse(plus_pulse), .minus_pulse(minus_pulse), .restore_pulse(restore_pulse),
      .stop_state(stop_state), .next_hold(next_hold)
   );

   always #5 clksrc1_1 = ~clksrc1_1;

   int checks = 0;
   int failures = 0;
   int abs_cyc = 0;
   int tph = 0;
   int sw_cnt = 0, plus_cnt = 0, minus_cnt = 0, restore_cnt = 0, nh_falls = 0;
   logic nh_prev = 1'b0;

   typedef struct {
      int             cyc;
      int             sig;
      logic [NSW-1:0] val;
      string          tag;
   } exp_t;
   exp_t exp_q[$];

   // Bench-side divider model: phase 3 of every 4 cycles after reset is a tick.
   always @(posedge clksrc1_1) begin
      abs_cyc <= abs_cyc + 1;
      tph     <= reset ? 0 : (tph + 1) % TICK_DIV;
   end

   function automatic logic [NSW-1:0] sig_val(int s);
      case (s)
         S_CLEAN:   return clean;
         S_RISE:    return sw_rise;
         S_PLUS:    return NSW'(plus_pulse);
         S_MINUS:   return NSW'(minus_pulse);
         S_RESTORE: return NSW'(restore_pulse);
         S_STOP:    return NSW'(stop_state);
         S_NHOLD:   return NSW'(next_hold);
         default:   return NSW'(ms_tick);
      endcase
   endfunction

   task automatic expect_at(int cyc, int sig, logic [NSW-1:0] val, string tag);
      exp_t e;
      e.cyc = cyc; e.sig = sig; e.val = val; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic chk(string tag, int obs, int expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   always @(negedge clksrc1_1) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc == abs_cyc) begin
            checks++;
            assert (sig_val(exp_q[i].sig) === exp_q[i].val) else begin
               failures++;
               $error("FAIL %s cyc=%0d observed=%0h expected=%0h", exp_q[i].tag, abs_cyc,
                      sig_val(exp_q[i].sig), exp_q[i].val);
            end
            exp_q.delete(i);
         end
      end
      sw_cnt      += $countones(sw_rise);
      plus_cnt    += int'(plus_pulse);
      minus_cnt   += int'(minus_pulse);
      restore_cnt += int'(restore_pulse);
      if (nh_prev && !next_hold) nh_falls++;
      nh_prev = next_hold;
   end

   // First cycle the debounced level shows an input changed in the current cycle:
   // two synchroniser cycles, then acceptance on the DEB-th tick seen with the new value.
   function automatic int accept_cyc();
      int s, ph, first;
      s     = abs_cyc + 2;
      ph    = (tph + 2) % TICK_DIV;
      first = s + ((3 - ph) + TICK_DIV) % TICK_DIV;
      return first + (DEB - 1) * TICK_DIV + 1;
   endfunction

   task automatic step(int n);
      repeat (n) @(posedge clksrc1_1);
      #1;
   endtask

   task automatic run_to(int c);
      while (abs_cyc < c) step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, ta, tr, ta2;
      logic [NSW-1:0] both;

      // Reset state and tick cadence
      step(3);
      for (int s = 0; s < 8; s++) expect_at(abs_cyc, s, '0, "reset_out");
      reset = 1'b0;
      d = abs_cyc;
      for (int k = 0; k < 12; k++) expect_at(d + k, S_TICK, NSW'((k % TICK_DIV) == 3), "ms_tick");
      expect_at(d + 1, S_CLEAN, '0, "post_reset_clean");
      run_to(d + 12);

      // Glitch of two ticks on noisy[3]
      noisy[3] = 1'b1;
      ta = accept_cyc();
      step(8);
      noisy[3] = 1'b0;
      expect_at(ta, S_CLEAN, '0, "glitch_clean");
      expect_at(ta + 4, S_CLEAN, '0, "glitch_clean_late");
      expect_at(ta + 1, S_RISE, '0, "glitch_rise");
      run_to(ta + 8);
      chk("glitch_rise_cnt", sw_cnt, 0);

      // Held switch
      noisy[3] = 1'b1;
      ta = accept_cyc();
      expect_at(ta - 1, S_CLEAN, '0, "sw_clean_before");
      expect_at(ta, S_CLEAN, NSW'(1 << 3), "sw_clean_accept");
      expect_at(ta, S_RISE, '0, "sw_rise_early");
      expect_at(ta + 1, S_RISE, NSW'(1 << 3), "sw_rise_pulse");
      expect_at(ta + 2, S_RISE, '0, "sw_rise_end");
      run_to(ta + 4);
      chk("sw_rise_cnt", sw_cnt, 1);

      // Stop toggle: press/hold, release, press, release, press
      stop_key_n = 1'b0;
      ta = accept_cyc();
      expect_at(ta, S_STOP, '0, "stop_before");
      expect_at(ta + 1, S_STOP, NSW'(1), "stop_on");
      run_to(ta + 2);
      step(80);
      expect_at(abs_cyc, S_STOP, NSW'(1), "stop_held");
      stop_key_n = 1'b1;
      step(20);
      expect_at(abs_cyc, S_STOP, NSW'(1), "stop_released");
      stop_key_n = 1'b0;
      ta = accept_cyc();
      expect_at(ta, S_STOP, NSW'(1), "stop2_before");
      expect_at(ta + 1, S_STOP, '0, "stop2_off");
      run_to(ta + 2);
      stop_key_n = 1'b1;
      step(20);
      stop_key_n = 1'b0;
      ta = accept_cyc();
      expect_at(ta + 1, S_STOP, NSW'(1), "stop3_on");
      run_to(ta + 2);
      stop_key_n = 1'b1;
      step(20);

      // Next stretch: hold 10 ticks, release, expire
      next_key_n = 1'b0;
      ta = accept_cyc();
      expect_at(ta, S_NHOLD, '0, "nh_before");
      expect_at(ta + 1, S_NHOLD, NSW'(1), "nh_on");
      run_to(ta + 1);
      step(40);
      expect_at(abs_cyc, S_NHOLD, NSW'(1), "nh_held");
      next_key_n = 1'b1;
      tr = accept_cyc();
      expect_at(tr, S_NHOLD, NSW'(1), "nh_release");
      expect_at(tr + 4 * HOLD, S_NHOLD, NSW'(1), "nh_last");
      expect_at(tr + 4 * HOLD + 1, S_NHOLD, '0, "nh_expire");
      run_to(tr + 4 * HOLD + 2);
      chk("nh_falls_1", nh_falls, 1);

      // Re-press during the countdown keeps next_hold up
      next_key_n = 1'b0;
      ta = accept_cyc();
      run_to(ta + 8);
      next_key_n = 1'b1;
      tr = accept_cyc();
      run_to(tr + 5);
      next_key_n = 1'b0;
      ta2 = accept_cyc();
      expect_at(tr + 20, S_NHOLD, NSW'(1), "nh_repress_a");
      expect_at(tr + 21, S_NHOLD, NSW'(1), "nh_repress_b");
      expect_at(tr + 24, S_NHOLD, NSW'(1), "nh_repress_c");
      run_to(ta2 + 12);
      chk("nh_no_drop", nh_falls, 1);
      next_key_n = 1'b1;
      tr = accept_cyc();
      expect_at(tr + 4 * HOLD, S_NHOLD, NSW'(1), "nh2_last");
      expect_at(tr + 4 * HOLD + 1, S_NHOLD, '0, "nh2_expire");
      run_to(tr + 4 * HOLD + 2);
      chk("nh_falls_2", nh_falls, 2);

      // Plus alone
      plus_key_n = 1'b0;
      ta = accept_cyc();
      expect_at(ta, S_PLUS, '0, "plus_early");
      expect_at(ta + 1, S_PLUS, NSW'(1), "plus_pulse");
      expect_at(ta + 2, S_PLUS, '0, "plus_end");
      run_to(ta + 3);
      plus_key_n = 1'b1;
      step(20);
      chk("plus_cnt_1", plus_cnt, 1);

      // Plus with minus cancels both
      plus_key_n = 1'b0;
      minus_key_n = 1'b0;
      ta = accept_cyc();
      expect_at(ta + 1, S_PLUS, '0, "pm_plus");
      expect_at(ta + 1, S_MINUS, '0, "pm_minus");
      run_to(ta + 3);
      plus_key_n = 1'b1;
      minus_key_n = 1'b1;
      step(20);
      chk("pm_plus_cnt", plus_cnt, 1);
      chk("pm_minus_cnt", minus_cnt, 0);

      // Minus alone
      minus_key_n = 1'b0;
      ta = accept_cyc();
      expect_at(ta + 1, S_MINUS, NSW'(1), "minus_pulse");
      expect_at(ta + 2, S_MINUS, '0, "minus_end");
      run_to(ta + 3);
      minus_key_n = 1'b1;
      step(20);
      chk("minus_cnt_1", minus_cnt, 1);

      // Plus with restore: restore only
      plus_key_n = 1'b0;
      restore_key_n = 1'b0;
      ta = accept_cyc();
      expect_at(ta + 1, S_RESTORE, NSW'(1), "pr_restore");
      expect_at(ta + 2, S_RESTORE, '0, "pr_restore_end");
      expect_at(ta + 1, S_PLUS, '0, "pr_plus");
      run_to(ta + 3);
      plus_key_n = 1'b1;
      restore_key_n = 1'b1;
      step(20);
      chk("pr_restore_cnt", restore_cnt, 1);
      chk("pr_plus_cnt", plus_cnt, 1);

      // Reset while next_hold counts down and noisy[5] is mid-debounce
      next_key_n = 1'b0;
      ta = accept_cyc();
      run_to(ta + 4);
      next_key_n = 1'b1;
      tr = accept_cyc();
      run_to(tr + 6);
      noisy[5] = 1'b1;
      step(6);
      reset = 1'b1;
      step(2);
      expect_at(abs_cyc, S_NHOLD, '0, "rst_mid_nh");
      expect_at(abs_cyc, S_CLEAN, '0, "rst_mid_clean");
      expect_at(abs_cyc, S_STOP, '0, "rst_mid_stop");
      reset = 1'b0;
      d = abs_cyc;
      ta = accept_cyc();
      for (int k = 0; k < 3; k++) begin
         expect_at(d + k, S_NHOLD, '0, "rel_nh");
         expect_at(d + k, S_CLEAN, '0, "rel_clean");
         expect_at(d + k, S_RISE, '0, "rel_rise");
         expect_at(d + k, S_PLUS, '0, "rel_plus");
         expect_at(d + k, S_MINUS, '0, "rel_minus");
         expect_at(d + k, S_RESTORE, '0, "rel_restore");
      end
      both = NSW'((1 << 3) | (1 << 5));
      expect_at(ta - 1, S_CLEAN, '0, "rel_clean_before");
      expect_at(ta, S_CLEAN, both, "rel_clean_accept");
      expect_at(ta + 1, S_RISE, both, "rel_rise_pulse");
      expect_at(ta + 2, S_RISE, '0, "rel_rise_end");
      run_to(ta + 4);
      chk("rel_rise_cnt", sw_cnt, 3);
      chk("exp_q_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
